// File: rtl/gba_rom_burst_sequencer_pkg.sv
// Shared definitions for the GBA ROM burst sequencer: state encodings, bus idle levels
// and minimum timing constants.
package gba_rom_burst_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LATCH,
        ST_TURN,
        ST_RD_LO,
        ST_RD_HI,
        ST_DONE,
        ST_DONE_RELATCH,
        ST_ABORT
    } seq_state_e;

    localparam logic CS_IDLE  = 1'b1;
    localparam logic RD_IDLE  = 1'b1;
    localparam logic WR_LEVEL = 1'b1;

    localparam int unsigned MIN_ADDR_SETUP = 1;
    localparam int unsigned MIN_RD_LOW     = 1;
    localparam int unsigned MIN_RD_HIGH    = 1;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gba_rom_burst_sequencer_cycle_timer.sv
// Loadable down-counter: done_o rises on the load_val_i-th cycle after a load and stays
// high until the next load.
module gba_cycle_timer #(
    parameter int unsigned W = 3
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i - W'(1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/gba_rom_burst_sequencer.sv
// Autonomous GBA cartridge ROM burst reader: drives CS/RD/AD timing and streams halfwords out.
// Optional running checksum of delivered halfwords when GBA_SEQ_CHECKSUM_EN is defined.
module gba_rom_burst_sequencer
    import gba_rom_burst_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_SETUP = 2,
    parameter int unsigned RD_LOW     = 4,
    parameter int unsigned RD_HIGH    = 2,
    parameter int unsigned LEN_W      = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [23:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_last,
    output logic             busy,
    output logic             CS,
    output logic             RD,
    output logic             WR,
    output logic [7:0]       A_HI,
    output logic [15:0]      AD_OUT,
    output logic             AD_OE,
    input  logic [15:0]      AD_IN
`ifdef GBA_SEQ_CHECKSUM_EN
    ,
    output logic [15:0]      csum_out,
    output logic             csum_valid
`endif
);

    localparam int unsigned SETUP_C = max2(ADDR_SETUP, MIN_ADDR_SETUP);
    localparam int unsigned LOW_C   = max2(RD_LOW, MIN_RD_LOW);
    localparam int unsigned HIGH_C  = max2(RD_HIGH, MIN_RD_HIGH);
    localparam int unsigned TW      = $clog2(max2(SETUP_C, max2(LOW_C, HIGH_C)) + 1);

    seq_state_e       state_q, state_d;
    logic [23:0]      addr_q;
    logic [LEN_W-1:0] cnt_q;
    logic             cs_q, rd_q, ad_oe_q;
    logic [15:0]      ad_out_q;
    logic [7:0]       a_hi_q;
    logic             out_valid_q, out_last_q;
    logic [15:0]      out_data_q;

    logic             accept, fire, slot_free, capture;
    logic             tmr_load, tmr_done;
    logic [TW-1:0]    tmr_val;
    logic [23:0]      addr_n;

    gba_cycle_timer #(.W(TW)) u_timer (
        .clk_i      (CLK),
        .rst_n_i    (RST_N),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // A beat aborted in the same cycle as out_ready is treated as not delivered.
    always_comb begin
        accept    = cmd_valid && (state_q == ST_IDLE);
        fire      = out_valid_q && out_ready && !abort;
        slot_free = !out_valid_q || out_ready;
        capture   = (state_q == ST_RD_LO) && tmr_done && !abort;
        addr_n    = accept ? cmd_addr : addr_q;
        state_d   = state_q;
        case (state_q)
            ST_IDLE:         if (accept && cmd_len != '0) state_d = ST_ADDR;
            ST_ADDR:         if (tmr_done) state_d = ST_LATCH;
            ST_LATCH:        state_d = ST_TURN;
            ST_TURN:         if (slot_free) state_d = ST_RD_LO;
            ST_RD_LO:        if (tmr_done) state_d = ST_RD_HI;
            ST_RD_HI: begin
                if (tmr_done) begin
                    if (cnt_q == '0)                state_d = ST_DONE;
                    else if (addr_q[15:0] == '0)    state_d = ST_DONE_RELATCH;
                    else if (slot_free)             state_d = ST_RD_LO;
                end
            end
            ST_DONE:         if (!out_valid_q || fire) state_d = ST_IDLE;
            ST_DONE_RELATCH: state_d = ST_ADDR;
            ST_ABORT:        state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase
        if (abort && state_q != ST_IDLE && state_q != ST_ABORT) state_d = ST_ABORT;
    end

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (state_d != state_q) begin
            case (state_d)
                ST_ADDR:  begin tmr_load = 1'b1; tmr_val = TW'(SETUP_C); end
                ST_RD_LO: begin tmr_load = 1'b1; tmr_val = TW'(LOW_C);   end
                ST_RD_HI: begin tmr_load = 1'b1; tmr_val = TW'(HIGH_C);  end
                default:  ;
            endcase
        end
    end

    // Bus pins are registered from the next state so they change exactly on state entry.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            cs_q        <= CS_IDLE;
            rd_q        <= RD_IDLE;
            ad_oe_q     <= 1'b0;
            ad_out_q    <= '0;
            a_hi_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                addr_q <= cmd_addr;
                cnt_q  <= cmd_len;
            end else if (capture) begin
                addr_q <= addr_q + 24'd1;
                cnt_q  <= cnt_q - LEN_W'(1);
            end

            if (capture) begin
                out_valid_q <= 1'b1;
                out_data_q  <= AD_IN;
                out_last_q  <= (cnt_q == LEN_W'(1));
            end else if (fire || state_d == ST_ABORT) begin
                out_valid_q <= 1'b0;
            end

            case (state_d)
                ST_LATCH, ST_TURN, ST_RD_LO, ST_RD_HI: cs_q <= 1'b0;
                ST_ABORT:                              cs_q <= cs_q;
                default:                               cs_q <= CS_IDLE;
            endcase
            rd_q    <= (state_d == ST_RD_LO) ? 1'b0 : RD_IDLE;
            ad_oe_q <= (state_d == ST_ADDR) || (state_d == ST_LATCH);

            if (state_d == ST_ADDR || state_d == ST_DONE_RELATCH) begin
                a_hi_q <= addr_n[23:16];
            end
            if (state_d == ST_ADDR) begin
                ad_out_q <= addr_n[15:0];
            end
        end
    end

`ifdef GBA_SEQ_CHECKSUM_EN
    logic [15:0] csum_q;
    logic        csum_valid_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            csum_q       <= '0;
            csum_valid_q <= 1'b0;
        end else begin
            if (accept)    csum_q <= '0;
            else if (fire) csum_q <= csum_q + out_data_q;
            csum_valid_q <= (state_q == ST_DONE) && (state_d == ST_IDLE);
        end
    end

    assign csum_out   = csum_q;
    assign csum_valid = csum_valid_q;
`endif

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign CS        = cs_q;
    assign RD        = rd_q;
    assign WR        = WR_LEVEL;
    assign A_HI      = a_hi_q;
    assign AD_OUT    = ad_out_q;
    assign AD_OE     = ad_oe_q;

endmodule
